axi_sram_slave: RTL and testbench

- AXI3-style 32-bit slave that acts as the memory-side responder for the CPU's AXI bridge. It serves the ar/r/aw/w/b channels from an internal word-addressed RAM.
- Main use is as the simulation and FPGA memory model behind the CPU top. It supports read bursts (cache-refill ready), single-beat strobed writes and programmable response latency.
- Reads and writes run in independent FSMs. Each FSM has at most one outstanding transaction.

---
 rtl/axi_defs_pkg.sv | 29 ++
 rtl/sram_1r1w_bytewe.sv | 32 +++
 rtl/axi_sram_slave.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_defs_pkg.sv
// rtl/axi_defs_pkg.sv - shared AXI field widths, response codes and FSM encodings
package axi_defs_pkg;

    localparam int ID_W   = 4;
    localparam int DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Delay counters are shared in width so that either latency fits; never narrower than 1 bit.
    function automatic int cnt_width(input int rd_delay, input int wr_delay);
        int m;
        m = (rd_delay > wr_delay) ? rd_delay : wr_delay;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sram_1r1w_bytewe.sv
// rtl/sram_1r1w_bytewe.sv - word RAM, combinational read port, synchronous byte-enabled write port
module sram_1r1w_bytewe #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic [DATA_W-1:0]     wdata
);

    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wbe[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // A read in the same cycle as a write to that word returns the pre-write contents.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 32-bit memory slave: INCR read bursts, single-beat strobed writes
module axi_sram_slave
    import axi_defs_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int RD_DELAY = 2,
    parameter int WR_DELAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int CNT_W = cnt_width(RD_DELAY, WR_DELAY);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_DELAY);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_DELAY);

    logic unused_inputs;
    assign unused_inputs = ^{arlen[7:4], arsize, arburst, wid, wlast,
                             araddr[31:ADDR_W+2], araddr[1:0],
                             awaddr[31:ADDR_W+2], awaddr[1:0]};

    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [3:0]        ram_wbe;
    logic [DATA_W-1:0] ram_wdata;

    sram_1r1w_bytewe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wbe   (ram_wbe),
        .wdata (ram_wdata)
    );

    rd_state_e         r_state_q, r_state_d;
    logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ADDR_W-1:0] r_idx_q, r_idx_d;
    logic [3:0]        r_beats_q, r_beats_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_beats_q <= '0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_beats_q <= r_beats_d;
            r_data_q  <= r_data_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_id_d    = r_id_q;
        r_idx_d   = r_idx_q;
        r_beats_d = r_beats_q;
        r_data_d  = r_data_q;
        ram_raddr = r_idx_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_id_d    = arid;
                    r_idx_d   = araddr[ADDR_W+1:2];
                    r_beats_d = arlen[3:0];
                    r_cnt_d   = RD_LOAD;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) begin
                    r_data_d  = ram_rdata;
                    r_state_d = R_DATA;
                end else begin
                    r_cnt_d = r_cnt_q - 1'b1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (r_beats_q == '0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        // Fetch the next word during the accepting cycle so beats stream without bubbles.
                        ram_raddr = r_idx_q + 1'b1;
                        r_idx_d   = r_idx_q + 1'b1;
                        r_beats_d = r_beats_q - 1'b1;
                        r_data_d  = ram_rdata;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_state_q == R_IDLE);
        rvalid  = (r_state_q == R_DATA);
        rlast   = (r_state_q == R_DATA) && (r_beats_q == '0);
    end

    assign rid   = r_id_q;
    assign rdata = r_data_q;
    assign rresp = RESP_OKAY;

    wr_state_e         w_state_q, w_state_d;
    logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [ADDR_W-1:0] aw_idx_q, aw_idx_d;
    logic              aw_bad_q, aw_bad_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic [ID_W-1:0]   b_id_q, b_id_d;
    logic [1:0]        b_resp_q, b_resp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_id_q   <= '0;
            aw_idx_q  <= '0;
            aw_bad_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_id_q    <= '0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            aw_id_q   <= aw_id_d;
            aw_idx_q  <= aw_idx_d;
            aw_bad_q  <= aw_bad_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            b_id_q    <= b_id_d;
            b_resp_q  <= b_resp_d;
        end
    end

    logic              aw_fire, w_fire;
    logic [ADDR_W-1:0] cur_idx;
    logic [ID_W-1:0]   cur_id;
    logic              cur_bad;
    logic [DATA_W-1:0] cur_data;
    logic [3:0]        cur_strb;

    // Whichever half arrives first is parked; the write commits on the cycle the pair completes.
    always_comb begin
        aw_fire   = awvalid && awready;
        w_fire    = wvalid && wready;
        cur_idx   = aw_got_q ? aw_idx_q : awaddr[ADDR_W+1:2];
        cur_id    = aw_got_q ? aw_id_q : awid;
        cur_bad   = aw_got_q ? aw_bad_q : (awlen != 8'd0);
        cur_data  = w_got_q ? w_data_q : wdata;
        cur_strb  = w_got_q ? w_strb_q : wstrb;
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        aw_id_d   = aw_id_q;
        aw_idx_d  = aw_idx_q;
        aw_bad_d  = aw_bad_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        b_id_d    = b_id_q;
        b_resp_d  = b_resp_q;
        ram_we    = 1'b0;
        ram_waddr = cur_idx;
        ram_wbe   = cur_strb;
        ram_wdata = cur_data;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_got_d = 1'b1;
                    aw_id_d  = awid;
                    aw_idx_d = awaddr[ADDR_W+1:2];
                    aw_bad_d = (awlen != 8'd0);
                end
                if (w_fire) begin
                    w_got_d  = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                if ((aw_got_q || aw_fire) && (w_got_q || w_fire)) begin
                    ram_we    = !cur_bad;
                    b_id_d    = cur_id;
                    b_resp_d  = cur_bad ? RESP_SLVERR : RESP_OKAY;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_cnt_d   = WR_LOAD;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == '0) begin
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - 1'b1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (w_state_q == W_IDLE) && !aw_got_q;
        wready  = (w_state_q == W_IDLE) && !w_got_q;
        bvalid  = (w_state_q == W_RESP);
    end

    assign bid   = b_id_q;
    assign bresp = b_resp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed, table-driven bench for axi_sram_slave
module tb_axi_sram_slave;

    logic        clk, rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int n_cmp = 0;
    int n_err = 0;

    axi_sram_slave #(.ADDR_W(16), .RD_DELAY(2), .WR_DELAY(1)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [7:0] l, input logic [3:0] id,
                             output logic [1:0] resp, output logic [3:0] bid_o);
        bit aw_done, w_done, aw_ok, w_ok;
        int t;
        aw_done = 0; w_done = 0;
        awaddr = a; awlen = l; awid = id; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        t = 0;
        while (!(aw_done && w_done) && t < 20) begin
            aw_ok = awvalid && awready;
            w_ok  = wvalid && wready;
            tick();
            if (aw_ok) begin awvalid = 1'b0; aw_done = 1; end
            if (w_ok)  begin wvalid = 1'b0;  w_done = 1;  end
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) timeout("write_addr_data");
        t = 0;
        while (!bvalid && t < 20) begin tick(); t++; end
        if (!bvalid) timeout("write_resp");
        resp = bresp; bid_o = bid;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read1(input logic [31:0] a, input logic [3:0] id,
                             output logic [31:0] d, output logic [3:0] rid_o);
        int t;
        araddr = a; arlen = 8'd0; arid = id; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 20) begin tick(); t++; end
        if (!arready) timeout("read_addr");
        tick();
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 20) begin tick(); t++; end
        if (!rvalid) timeout("read_data");
        d = rdata; rid_o = rid;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [7:0]  len;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] rd;
        logic [3:0]  rdid, bidv;
        logic [1:0]  resp;
        int          k, beat, t;
        bit          pat[5];
        bit          got_r, got_b;

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 4'hF, 8'd0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'h0000_0002, 4'hF, 8'd0, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0008, 32'h0000_0003, 4'hF, 8'd0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_000C, 32'h0000_0004, 4'hF, 8'd0, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 8'd0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 8'd0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 8'd0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0100, 32'h0000_0000, 4'h8, 8'd0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 8'd0, 32'h00FF_FFFF};
        vecs[9]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'h0, 8'd0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 8'd0, 32'h00FF_FFFF};
        vecs[11] = '{1'b0, 32'h0004_0040, 32'h0, 4'h0, 8'd0, 32'hDEAD_BEEF};
        vecs[12] = '{1'b1, 32'h0000_0040, 32'h0000_0000, 4'hF, 8'd1, 32'h2};
        vecs[13] = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 8'd0, 32'hDEAD_BEEF};
        vecs[14] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 8'd0, 32'h0000_0001};

        rst = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b1; wvalid = 1'b0; bready = 1'b0;
        tick(); tick();

        chk("rst_arready", {31'b0, arready}, 32'd1);
        chk("rst_awready", {31'b0, awready}, 32'd1);
        chk("rst_wready",  {31'b0, wready},  32'd1);
        chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
        chk("rst_rlast",   {31'b0, rlast},   32'd0);
        chk("rst_rid",     {28'b0, rid},     32'd0);
        chk("rst_bid",     {28'b0, bid},     32'd0);
        chk("rst_rdata",   rdata,            32'd0);
        chk("rst_rresp",   {30'b0, rresp},   32'd0);
        chk("rst_bresp",   {30'b0, bresp},   32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].len, 4'(i), resp, bidv);
                chk($sformatf("vec%0d_bresp", i), {30'b0, resp}, vecs[i].exp);
                chk($sformatf("vec%0d_bid", i), {28'b0, bidv}, 32'(i[3:0]));
            end else begin
                axi_read1(vecs[i].addr, 4'(i), rd, rdid);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
                chk($sformatf("vec%0d_rid", i), {28'b0, rdid}, 32'(i[3:0]));
            end
        end

        // Single read latency: handshake edge to rvalid is RD_DELAY+1 = 3 cycles
        araddr = 32'h40; arid = 4'd1; arlen = 8'd0; arvalid = 1'b1;
        chk("lat_arready_idle", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        chk("lat_arready_busy", {31'b0, arready}, 32'd0);
        k = 0;
        while (!rvalid && k < 20) begin tick(); k++; end
        chk("lat_cycles", 32'(k), 32'd3);
        chk("lat_rdata", rdata, 32'hDEAD_BEEF);
        chk("lat_rid", {28'b0, rid}, 32'd1);
        chk("lat_rlast", {31'b0, rlast}, 32'd1);
        chk("lat_rresp", {30'b0, rresp}, 32'd0);
        rready = 1'b1; tick(); rready = 1'b0;
        chk("lat_rvalid_drop", {31'b0, rvalid}, 32'd0);

        // Burst of 4 with one stall cycle
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 1;
        araddr = 32'h0; arid = 4'd5; arlen = 8'd3; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 20) begin tick(); t++; end
        if (!rvalid) timeout("burst_first_beat");
        beat = 0;
        for (int i = 0; i < 5; i++) begin
            rready = pat[i];
            chk($sformatf("burst%0d_rdata", i), rdata, 32'(beat + 1));
            chk($sformatf("burst%0d_rlast", i), {31'b0, rlast}, 32'(beat == 3));
            chk($sformatf("burst%0d_arready", i), {31'b0, arready}, 32'd0);
            if (rvalid && rready) beat++;
            tick();
        end
        rready = 1'b0;
        chk("burst_beats", 32'(beat), 32'd4);
        chk("burst_rvalid_end", {31'b0, rvalid}, 32'd0);
        chk("burst_arready_end", {31'b0, arready}, 32'd1);

        // W ahead of AW by two cycles, strobed merge, held response
        axi_write(32'h8, 32'h1122_3344, 4'hF, 8'd0, 4'd9, resp, bidv);
        wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wfirst_wready", {31'b0, wready}, 32'd0);
        chk("wfirst_awready", {31'b0, awready}, 32'd1);
        tick(); tick();
        awaddr = 32'h8; awid = 4'd2; awlen = 8'd0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        k = 0;
        while (!bvalid && k < 20) begin tick(); k++; end
        chk("wfirst_bcycles", 32'(k), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("wfirst_bhold%0d", i), {31'b0, bvalid}, 32'd1);
        end
        chk("wfirst_bid", {28'b0, bid}, 32'd2);
        chk("wfirst_bresp", {30'b0, bresp}, 32'd0);
        bready = 1'b1; tick(); bready = 1'b0;
        chk("wfirst_bvalid_drop", {31'b0, bvalid}, 32'd0);
        axi_read1(32'h8, 4'd0, rd, rdid);
        chk("wfirst_merge", rd, 32'h11BB_33DD);

        // AR and AW+W accepted in the same cycle
        araddr = 32'h4; arid = 4'd3; arlen = 8'd0; arvalid = 1'b1;
        awaddr = 32'hC; awid = 4'd4; awlen = 8'd0; awvalid = 1'b1;
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        chk("conc_ready_all", {29'b0, arready, awready, wready}, 32'h7);
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rready = 1'b1; bready = 1'b1;
        got_r = 0; got_b = 0; t = 0;
        while (!(got_r && got_b) && t < 30) begin
            if (rvalid) begin got_r = 1; rd = rdata; rdid = rid; end
            if (bvalid) begin got_b = 1; bidv = bid; resp = bresp; end
            tick();
            t++;
        end
        rready = 1'b0; bready = 1'b0;
        if (!(got_r && got_b)) timeout("concurrent");
        chk("conc_rdata", rd, 32'd2);
        chk("conc_rid", {28'b0, rdid}, 32'd3);
        chk("conc_bid", {28'b0, bidv}, 32'd4);
        chk("conc_bresp", {30'b0, resp}, 32'd0);
        axi_read1(32'hC, 4'd0, rd, rdid);
        chk("conc_written", rd, 32'hCAFE_F00D);

        // Asynchronous reset while a burst beat is pending
        araddr = 32'h0; arid = 4'd7; arlen = 8'd3; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 20) begin tick(); t++; end
        chk("mid_rvalid_before", {31'b0, rvalid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rvalid_async", {31'b0, rvalid}, 32'd0);
        chk("mid_arready_async", {31'b0, arready}, 32'd1);
        chk("mid_rlast_async", {31'b0, rlast}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("mid_no_stale%0d", i), {31'b0, rvalid}, 32'd0);
        end
        rready = 1'b0;
        axi_read1(32'h0, 4'd6, rd, rdid);
        chk("mid_after_read", rd, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
